// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM pipeline stage.
//   - funct3 encodings for load/store access size and signedness
//   - FSM state type for the data-memory access sequencer
//   - default WAIT timeout
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } mem_state_e;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/halfword lane of a 32-bit
// memory word and sign- or zero-extends it according to funct3.
//   rdata  : raw 32-bit word returned by data memory
//   addr   : low two bits of the effective address
//   funct3 : access size/sign (B, H, W, BU, HU)
//   data32 : aligned, extended load result
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data32
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];

        data32 = rdata;
        case (funct3)
            F3_B:    data32 = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data32 = {24'h0, w_byte};
            F3_H:    data32 = {{16{w_half[15]}}, w_half};
            F3_HU:   data32 = {16'h0, w_half};
            default: data32 = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Issues loads/stores to data memory
// over a valid/ready request channel, waits for the response channel,
// aligns load data, generates store strobes, and stalls the pipeline while
// an access is outstanding. Results go combinationally to mem_wb.
//   clk, rst                  : clock, synchronous active-high reset
//   valid_in .. MemWrite_in   : instruction and controls from EX/MEM
//   dmem_req_* / dmem_addr    : request channel (valid/ready handshake)
//   dmem_we/wdata/wstrb       : store controls
//   dmem_rvalid / dmem_rdata  : response channel
//   *_out                     : results to mem_wb, stall, exception pulses
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] StoreData_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALU_result_out,
    output logic [31:0] MemReadData_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    mem_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;

    logic        w_mem_op, w_misaligned, w_timeout;
    logic        w_req, w_stall, w_mis, w_berr, w_resp;
    logic [31:0] w_st_data, w_load_data;
    logic [3:0]  w_st_strb;

    assign w_mem_op     = valid_in & (MemRead_in | MemWrite_in);
    assign w_misaligned = ((funct3_in[1:0] == 2'b10) & (|ALU_result_in[1:0])) |
                          ((funct3_in[1:0] == 2'b01) & ALU_result_in[0]);
    // Aborts on the TIMEOUT_CYCLES-th WAIT cycle, so WAIT never lasts longer.
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            // Held at zero outside WAIT, so it is clear on every WAIT entry.
            r_cnt   <= (r_state == ST_WAIT) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_mis        = 1'b0;
        w_berr       = 1'b0;
        w_resp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        w_mis = 1'b1;
                    end else begin
                        w_req        = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = dmem_req_ready ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // EX/MEM is frozen by the stall, so the request stays stable.
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem_req_ready) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the timeout cycle still completes.
                if (dmem_rvalid) begin
                    w_resp       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_berr       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_st_data = StoreData_in;
        w_st_strb = 4'b1111;
        case (funct3_in[1:0])
            2'b00: begin
                w_st_data = {4{StoreData_in[7:0]}};
                w_st_strb = 4'b0001 << ALU_result_in[1:0];
            end
            2'b01: begin
                w_st_data = {2{StoreData_in[15:0]}};
                w_st_strb = 4'b0011 << {ALU_result_in[1], 1'b0};
            end
            default: begin
                w_st_data = StoreData_in;
                w_st_strb = 4'b1111;
            end
        endcase
    end

    mem_load_align u_align (
        .rdata  (dmem_rdata),
        .addr   (ALU_result_in[1:0]),
        .funct3 (funct3_in),
        .data32 (w_load_data)
    );

    assign dmem_req_valid  = ~rst & w_req;
    assign dmem_addr       = {ALU_result_in[31:2], 2'b00};
    assign dmem_we         = ~rst & w_req & MemWrite_in;
    assign dmem_wdata      = MemWrite_in ? w_st_data : '0;
    assign dmem_wstrb      = MemWrite_in ? w_st_strb : 4'b1111;

    assign ALU_result_out  = ALU_result_in;
    assign rd_out          = rd_in;
    assign MemToReg_out    = ~rst & MemToReg_in;
    assign MemReadData_out = (~rst & w_resp & MemRead_in) ? w_load_data : '0;
    assign RegWrite_out    = ~rst & valid_in & RegWrite_in & ~w_stall & ~w_mis & ~w_berr;
    assign stall_out       = ~rst & w_stall;
    assign misaligned_out  = ~rst & w_mis;
    assign bus_error_out   = ~rst & w_berr;

endmodule
